// File: rtl/token_encoder_pkg.sv
// Shared definitions for the token_encoder slice.
//   tok_enc_state_t : controller state names (encoded as 3-bit values)
//   DEF_DATA_WIDTH  : default symbol width
//   DEF_TOK_LEN     : default maximum symbols per vocab entry
//   TERM_SYM        : terminator / padding symbol value
package token_encoder_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHK_END = 3'd1,
    FETCH   = 3'd2,
    COMPARE = 3'd3,
    RESOLVE = 3'd4,
    EMIT    = 3'd5,
    DONE    = 3'd6
  } tok_enc_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TOK_LEN    = 4;
  localparam logic [DEF_DATA_WIDTH-1:0] TERM_SYM = '0;

endpackage

// File: rtl/token_encoder_matcher.sv
// Symbol matcher for one vocab entry against the input at the current position.
// Holds the symbol index k and classifies each compared symbol pair.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous clear of k
//   compare_en   voc_sym/in_sym carry valid memory data this cycle
//   voc_sym      vocab symbol at entry*TOK_LEN+k
//   in_sym       input symbol at pos+k (already forced to terminator past the end)
//   k            current symbol index within the entry
//   match_len    length of a full match (valid with match)
//   end_vocab    empty entry found: no further vocab entries
//   match        entry fully matched
//   mismatch     entry differs from input
//   step         symbols agree, compare the next one
module token_encoder_matcher
  import token_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TOK_LEN    = DEF_TOK_LEN,
  localparam int LEN_W     = $clog2(TOK_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  compare_en,
  input  logic [DATA_WIDTH-1:0] voc_sym,
  input  logic [DATA_WIDTH-1:0] in_sym,
  output logic [LEN_W-1:0]      k,
  output logic [LEN_W-1:0]      match_len,
  output logic                  end_vocab,
  output logic                  match,
  output logic                  mismatch,
  output logic                  step
);

  logic voc_term;
  logic sym_eq;
  logic last_k;

  assign voc_term = (voc_sym == DATA_WIDTH'(TERM_SYM));
  assign sym_eq   = (voc_sym == in_sym);
  assign last_k   = (k == LEN_W'(TOK_LEN - 1));

  // A terminator in the vocab is checked first: at k==0 it marks the end of
  // the table, later it ends the entry as a full match. Symbol equality with a
  // nonzero vocab symbol implies the input symbol is nonzero too.
  assign end_vocab = compare_en && voc_term && (k == '0);
  assign match     = compare_en && ((voc_term && (k != '0)) || (!voc_term && sym_eq && last_k));
  assign mismatch  = compare_en && !voc_term && !sym_eq;
  assign step      = compare_en && !voc_term && sym_eq && !last_k;
  assign match_len = voc_term ? k : LEN_W'(TOK_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
    end else if (clear) begin
      k <= '0;
    end else if (step) begin
      k <= k + LEN_W'(1);
    end else if (match || mismatch) begin
      k <= '0;
    end
  end

endmodule

// File: rtl/token_encoder.sv
// Greedy longest-match tokenizer. Walks a zero-terminated string in input
// memory, scans every vocab entry at each position, and emits the index of the
// longest matching entry (lowest index on ties) on a valid/ready stream.
// Optional feature macro: UNK_FALLBACK_EN -- unmatched symbols emit UNK_CODE
// with length 1 instead of raising err and stopping.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cs           start request, sampled in IDLE
//   in_addr      input memory address (sync read, data next cycle)
//   in_rdata     input memory data
//   voc_addr     vocab memory address (sync read, data next cycle)
//   voc_rdata    vocab memory data
//   code_valid   code_data/code_len valid
//   code_ready   sink accepts the code
//   code_data    emitted vocab index
//   code_len     symbols consumed by the code
//   err          unmatched symbol seen (held until back in IDLE)
//   done         string fully processed
//
// state   | meaning
// IDLE    | waiting for cs, in[0] being read
// CHK_END | in[pos] available; terminator ends the run
// FETCH   | addresses for entry/k presented
// COMPARE | vocab and input symbols available, matcher decides
// RESOLVE | all entries scanned, choose emit or error
// EMIT    | code held on the stream until accepted
// DONE    | done asserted until cs drops
module token_encoder
  import token_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IN_ADDR_W  = 4,
  parameter int NUM_TOKENS = 16,
  parameter int TOK_LEN    = DEF_TOK_LEN,
  parameter int VOC_ADDR_W = 6,
  parameter int UNK_CODE   = NUM_TOKENS - 1,
  localparam int CODE_W    = $clog2(NUM_TOKENS),
  localparam int LEN_W     = $clog2(TOK_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  output logic [IN_ADDR_W-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0] in_rdata,
  output logic [VOC_ADDR_W-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_rdata,
  output logic                  code_valid,
  input  logic                  code_ready,
  output logic [CODE_W-1:0]     code_data,
  output logic [LEN_W-1:0]      code_len,
  output logic                  err,
  output logic                  done
);

  localparam int POS_W = IN_ADDR_W + 1;

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_CHK_END = CHK_END;
  localparam logic [2:0] S_FETCH   = FETCH;
  localparam logic [2:0] S_COMPARE = COMPARE;
  localparam logic [2:0] S_RESOLVE = RESOLVE;
  localparam logic [2:0] S_EMIT    = EMIT;
  localparam logic [2:0] S_DONE    = DONE;

  logic [2:0]            state;
  // pos carries one extra bit so "one past the last address" is representable.
  logic [POS_W-1:0]      pos;
  logic [CODE_W-1:0]     entry;
  logic [CODE_W-1:0]     best_idx;
  logic [LEN_W-1:0]      best_len;
  logic                  past_end;

  logic [LEN_W-1:0]      k;
  logic [LEN_W-1:0]      match_len;
  logic                  m_end;
  logic                  m_match;
  logic                  m_miss;
  logic                  m_step;

  logic [POS_W-1:0]      fetch_pos;
  logic [POS_W-1:0]      next_pos;
  logic [DATA_WIDTH-1:0] in_sym;
  logic                  last_entry;

  assign fetch_pos  = pos + POS_W'(k);
  assign next_pos   = pos + POS_W'(best_len);
  assign last_entry = (entry == CODE_W'(NUM_TOKENS - 1));

  // Reads beyond the top of input memory must not wrap: the symbol is forced
  // to the terminator instead.
  always_comb begin
    in_sym = in_rdata;
    if (state == S_CHK_END) begin
      if (pos[IN_ADDR_W]) in_sym = '0;
    end else if (past_end) begin
      in_sym = '0;
    end
  end

  // Addresses are combinational so the 1-cycle read lands in the next state.
  // IDLE and EMIT already point at the symbol CHK_END will test.
  always_comb begin
    in_addr = pos[IN_ADDR_W-1:0];
    case (state)
      S_IDLE:  in_addr = '0;
      S_FETCH: in_addr = fetch_pos[IN_ADDR_W-1:0];
      S_EMIT:  in_addr = next_pos[IN_ADDR_W-1:0];
      default: in_addr = pos[IN_ADDR_W-1:0];
    endcase
  end

  assign voc_addr = (state == S_FETCH)
                  ? VOC_ADDR_W'(entry) * VOC_ADDR_W'(TOK_LEN) + VOC_ADDR_W'(k)
                  : '0;

  assign code_valid = (state == S_EMIT);
  assign code_data  = (state == S_EMIT) ? best_idx : '0;
  assign code_len   = (state == S_EMIT) ? best_len : '0;
  assign done       = (state == S_DONE);

  token_encoder_matcher #(
    .DATA_WIDTH (DATA_WIDTH),
    .TOK_LEN    (TOK_LEN)
  ) u_matcher (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state == S_IDLE),
    .compare_en (state == S_COMPARE),
    .voc_sym    (voc_rdata),
    .in_sym     (in_sym),
    .k          (k),
    .match_len  (match_len),
    .end_vocab  (m_end),
    .match      (m_match),
    .mismatch   (m_miss),
    .step       (m_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pos      <= '0;
      entry    <= '0;
      best_idx <= '0;
      best_len <= '0;
      past_end <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs) begin
            state    <= S_CHK_END;
            pos      <= '0;
            entry    <= '0;
            best_idx <= '0;
            best_len <= '0;
            err      <= 1'b0;
          end
        end
        S_CHK_END: begin
          state <= (in_sym == DATA_WIDTH'(TERM_SYM)) ? S_DONE : S_FETCH;
        end
        S_FETCH: begin
          past_end <= fetch_pos[IN_ADDR_W];
          state    <= S_COMPARE;
        end
        S_COMPARE: begin
          // Strict greater-than keeps the lowest index among equal lengths.
          if (m_match && (match_len > best_len)) begin
            best_len <= match_len;
            best_idx <= entry;
          end
          if (m_end) begin
            state <= S_RESOLVE;
          end else if (m_step) begin
            state <= S_FETCH;
          end else if (last_entry) begin
            state <= S_RESOLVE;
          end else begin
            entry <= entry + CODE_W'(1);
            state <= S_FETCH;
          end
        end
        S_RESOLVE: begin
          if (best_len != '0) begin
            state <= S_EMIT;
          end else begin
`ifdef UNK_FALLBACK_EN
            best_idx <= CODE_W'(UNK_CODE);
            best_len <= LEN_W'(1);
            state    <= S_EMIT;
`else
            err      <= 1'b1;
            state    <= S_DONE;
`endif
          end
        end
        S_EMIT: begin
          if (code_ready) begin
            pos      <= next_pos;
            best_len <= '0;
            best_idx <= '0;
            entry    <= '0;
            state    <= S_CHK_END;
          end
        end
        S_DONE: begin
          if (!cs) begin
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
